lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit between the RV32I execute stage and the word-addressed data memory.
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word memory reads and writes.
- Performs byte-lane extraction with sign or zero extension on loads, and a read-modify-write sequence for sub-word stores.
- Flags illegal, misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 64: depth of the attached data memory in 32-bit words; word indices at or above this are out of range.
- XLEN, 32: data and address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present; sampled only when req_ready=1
- req_ready  out  1  unit idle and able to accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  XLEN  word index, i.e. byte address >> 2
- mem_wdata  out  XLEN  word to write
- mem_rdata  in  XLEN  combinational read data from memory

Behaviour:
- States: IDLE, RMW_WR, DONE. Reset value: IDLE.
- Reset values: resp_valid=0, resp_rdata=0, resp_err=00, held word=0. mem_* are derived combinationally from state, so they drop on reset with no clock edge needed.
- req_ready = (state==IDLE).
- An accept is req_valid && req_ready.
- Error check on accept, in priority order:
  - illegal funct3 (011, 110, 111; also 100 or 101 with req_we=1) → 11
  - misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0) → 01
  - addr>>2 ≥ MEM_WORDS → 10
- On error: no mem_read or mem_write; next state DONE with resp_err set and resp_rdata=0.
- Load accept (IDLE):
  - mem_read=1, mem_addr=addr>>2.
  - mem_rdata is sampled at the clock edge. Lane = addr[1:0], little-endian; byte = bits 8*lane+7:8*lane; half = bits 16*addr[1]+15:16*addr[1].
  - B/H sign-extend, BU/HU zero-extend. Result is registered into resp_rdata. Next state DONE.
- SW accept: mem_write=1, mem_wdata=req_wdata in the accept cycle; next state DONE.
- SB/SH accept:
  - mem_read=1; the old word is latched together with the address, lane, size and wdata.
  - Next state RMW_WR: mem_write=1 for exactly one cycle; mem_wdata = latched word with the target lane replaced by req_wdata[7:0] or [15:0]; then DONE.
- DONE: resp_valid=1 for one cycle with resp_rdata/resp_err valid; next state IDLE. Next accept is possible in the cycle after DONE.
- Latency from accept to resp_valid: loads, SW and errors take 1 cycle; SB/SH take 2 cycles.
- mem_read and mem_write are never both 1. Outside the cases above, both are 0 and mem_addr/mem_wdata are don't-care (driven 0).
- req_* inputs are ignored while req_ready=0.
- Reset mid-operation: return to IDLE immediately, any RMW write is abandoned, and no resp_valid is produced for the lost request.
- The memory's own reset clears its contents; the LSU makes no assumption about preloaded values.

Decomposition:
- Shared package:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - resp_err codes ERR_OK/ERR_MISALIGN/ERR_RANGE/ERR_ILLEGAL
  - FSM state encoding
- One sub-module, lsu_lane_align: purely combinational. Performs load extraction/extension and store lane merge from (word, lane, size, signed, wdata). It is reused by the eventual cache path.

Test Plan:
- Word 4 = 0x8899AABB; LB addr 0x12 → resp_rdata=0xFFFFFF99, err 00, resp_valid exactly 1 cycle after accept, mem_read for 1 cycle, mem_addr=4.
- Same word; LBU 0x12 → 0x00000099. LHU 0x12 → 0x00008899. LH 0x10 → 0xFFFFAABB.
- SB addr 0x11, wdata 0x123456CC → word 4 becomes 0x8899CCBB. mem_read in the accept cycle, mem_write exactly one cycle (RMW_WR), resp_valid 2 cycles after accept.
- LH 0x13 → err 01. SW 0x100 (word 64) → err 10. funct3 100 with req_we=1 → err 11. In all three, no mem_read/mem_write.
- Back-to-back: SW then LW to the same address → LW returns the stored value. req_ready=0 in DONE and requests presented then are ignored.
- Assert rst during RMW_WR → mem_write falls with no clock edge, state IDLE, no resp_valid, and the word is unchanged in the memory model.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, response error
// codes, FSM encoding and access-size decoding.
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_WR = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Illegal codes fall through to SZ_W; they are rejected before size matters.
  function automatic size_t funct3_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: extracts and extends load data from a memory word, and
// merges sub-word store data into a word. Purely combinational.
module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = word[{lane, 3'b000} +: 8];
    half_val = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    load_data = {{24{is_signed & byte_val[7]}}, byte_val};
      SZ_H:    load_data = {{16{is_signed & half_val[15]}}, half_val};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (size)
      SZ_B:    store_word[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns byte-addressed RV32I loads/stores into word accesses
// on a combinational-read data memory, with read-modify-write for SB/SH.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t          state, state_next;
  logic            accept;
  logic            sub_store;
  logic            req_signed;
  logic            req_illegal;
  logic            req_misalign;
  logic            req_range;
  logic [1:0]      req_err;
  size_t           req_size;
  logic [XLEN-1:0] req_word_idx;

  logic [XLEN-1:0] held_word;
  logic [XLEN-1:0] held_addr;
  logic [XLEN-1:0] held_wdata;
  logic [1:0]      held_lane;
  size_t           held_size;
  logic [XLEN-1:0] rdata_q;
  logic [1:0]      err_q;

  logic [XLEN-1:0] align_word;
  logic [XLEN-1:0] align_wdata;
  logic [1:0]      align_lane;
  size_t           align_size;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;

  assign accept       = req_valid && (state == ST_IDLE);
  assign req_word_idx = {2'b00, req_addr[XLEN-1:2]};
  assign sub_store    = req_we && (req_size != SZ_W);

  always_comb begin
    req_size     = funct3_size(req_funct3);
    req_signed   = (req_funct3 == F3_B) || (req_funct3 == F3_H);
    case (req_funct3)
      F3_B, F3_H, F3_W: req_illegal = 1'b0;
      F3_BU, F3_HU:     req_illegal = req_we;
      default:          req_illegal = 1'b1;
    endcase
    req_misalign = ((req_size == SZ_H) && req_addr[0]) ||
                   ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    req_range    = req_word_idx >= XLEN'(MEM_WORDS);
    if (req_illegal)       req_err = ERR_ILLEGAL;
    else if (req_misalign) req_err = ERR_MISALIGN;
    else if (req_range)    req_err = ERR_RANGE;
    else                   req_err = ERR_OK;
  end

  // One aligner serves both the load path at accept and the merge in RMW_WR.
  assign align_word  = (state == ST_RMW_WR) ? held_word  : mem_rdata;
  assign align_wdata = (state == ST_RMW_WR) ? held_wdata : req_wdata;
  assign align_lane  = (state == ST_RMW_WR) ? held_lane  : req_addr[1:0];
  assign align_size  = (state == ST_RMW_WR) ? held_size  : req_size;

  lsu_lane_align u_align (
    .word       (align_word),
    .lane       (align_lane),
    .size       (align_size),
    .is_signed  (req_signed),
    .wdata      (align_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err == ERR_OK && sub_store) state_next = ST_RMW_WR;
          else                                state_next = ST_DONE;
        end
      end
      ST_RMW_WR: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept && req_err == ERR_OK) begin
          mem_addr = req_word_idx;
          if (!req_we || sub_store) begin
            mem_read = 1'b1;
          end else begin
            mem_write = 1'b1;
            mem_wdata = req_wdata;
          end
        end
      end
      ST_RMW_WR: begin
        mem_write = 1'b1;
        mem_addr  = held_addr;
        mem_wdata = store_word;
      end
      ST_DONE:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Response data and the RMW context are captured only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      err_q      <= ERR_OK;
      held_word  <= '0;
      held_addr  <= '0;
      held_wdata <= '0;
      held_lane  <= 2'b00;
      held_size  <= SZ_W;
    end else if (accept) begin
      err_q   <= req_err;
      rdata_q <= (req_err == ERR_OK && !req_we) ? load_data : '0;
      if (req_err == ERR_OK && sub_store) begin
        held_word  <= mem_rdata;
        held_addr  <= req_word_idx;
        held_wdata <= req_wdata;
        held_lane  <= req_addr[1:0];
        held_size  <= req_size;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a word memory model behind the LSU and a
// scoreboard of expected responses checked when resp_valid pulses.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [MEM_WORDS];

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          reads;
    int          writes;
  } exp_t;

  exp_t sb[$];

  lsu_mem_ctrl #(.MEM_WORDS(MEM_WORDS), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request, follows it to resp_valid, then offers a stray store
  // during DONE that must be ignored.
  task automatic apply_stimulus(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                                input int exp_lat, input int exp_reads,
                                input int exp_writes, input string tag);
    exp_t        e;
    exp_t        got;
    int          cyc;
    int          reads;
    int          writes;
    logic        both;
    logic        seen;
    logic [31:0] acc_addr;

    @(negedge clk);
    check_output({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.tag    = tag;
    e.rdata  = exp_rdata;
    e.err    = exp_err;
    e.lat    = exp_lat;
    e.reads  = exp_reads;
    e.writes = exp_writes;
    sb.push_back(e);
    #1;
    reads    = int'(mem_read);
    writes   = int'(mem_write);
    both     = mem_read & mem_write;
    acc_addr = mem_addr;
    cyc      = 0;
    seen     = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
      reads  += int'(mem_read);
      writes += int'(mem_write);
      both   |= mem_read & mem_write;
      if (resp_valid) seen = 1'b1;
    end
    check_output({tag, "_resp_seen"}, 32'(seen), 32'd1);
    got = sb.pop_front();
    check_output({tag, "_rdata"}, resp_rdata, got.rdata);
    check_output({tag, "_err"}, 32'(resp_err), 32'(got.err));
    check_output({tag, "_latency"}, cyc, got.lat);
    check_output({tag, "_mem_reads"}, reads, got.reads);
    check_output({tag, "_mem_writes"}, writes, got.writes);
    check_output({tag, "_rw_overlap"}, 32'(both), 32'd0);
    if (got.err == ERR_OK && (got.reads + got.writes) > 0)
      check_output({tag, "_mem_addr"}, acc_addr, addr >> 2);

    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h24;
    req_wdata  = 32'hDEADBEEF;
    #1;
    check_output({tag, "_done_ready"}, 32'(req_ready), 32'd0);
    check_output({tag, "_done_nomem"}, 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_output({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
    mem[4] <= 32'h8899AABB;
    mem[5] <= 32'h11223344;
    mem[6] <= 32'h55667788;
    repeat (2) @(negedge clk);

    check_output("reset_ready", 32'(req_ready), 32'd1);
    check_output("reset_resp_valid", 32'(resp_valid), 32'd0);
    check_output("reset_rdata", resp_rdata, 32'h0);
    check_output("reset_err", 32'(resp_err), 32'd0);
    check_output("reset_mem_rw", 32'({mem_read, mem_write}), 32'd0);
    rst = 1'b0;

    apply_stimulus(1'b0, F3_B,  32'h12, 32'h0, 32'hFFFFFF99, ERR_OK, 1, 1, 0, "lb_12");
    apply_stimulus(1'b0, F3_BU, 32'h12, 32'h0, 32'h00000099, ERR_OK, 1, 1, 0, "lbu_12");
    apply_stimulus(1'b0, F3_HU, 32'h12, 32'h0, 32'h00008899, ERR_OK, 1, 1, 0, "lhu_12");
    apply_stimulus(1'b0, F3_H,  32'h10, 32'h0, 32'hFFFFAABB, ERR_OK, 1, 1, 0, "lh_10");

    apply_stimulus(1'b1, F3_B, 32'h11, 32'h123456CC, 32'h0, ERR_OK, 2, 1, 1, "sb_11");
    check_output("sb_11_mem_word", mem[4], 32'h8899CCBB);
    apply_stimulus(1'b0, F3_W, 32'h10, 32'h0, 32'h8899CCBB, ERR_OK, 1, 1, 0, "lw_10");

    apply_stimulus(1'b0, F3_H,  32'h13,  32'h0, 32'h0, ERR_MISALIGN, 1, 0, 0, "lh_misalign");
    apply_stimulus(1'b1, F3_W,  32'h100, 32'h5, 32'h0, ERR_RANGE,    1, 0, 0, "sw_range");
    apply_stimulus(1'b1, F3_BU, 32'h10,  32'h5, 32'h0, ERR_ILLEGAL,  1, 0, 0, "store_bu");
    check_output("errors_mem_word", mem[4], 32'h8899CCBB);

    apply_stimulus(1'b1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, ERR_OK, 1, 0, 1, "sw_20");
    apply_stimulus(1'b0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, ERR_OK, 1, 1, 0, "lw_20");

    apply_stimulus(1'b1, F3_H, 32'h1A, 32'hFFFF1234, 32'h0, ERR_OK, 2, 1, 1, "sh_1a");
    check_output("sh_1a_mem_word", mem[6], 32'h12347788);
    apply_stimulus(1'b0, F3_B, 32'h1B, 32'h0, 32'h00000012, ERR_OK, 1, 1, 0, "lb_1b");
    check_output("done_stray_ignored", mem[9], 32'h0);

    // Reset lands while the RMW write is on the bus.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h16;
    req_wdata  = 32'h000000AB;
    #1;
    check_output("rst_sb_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("rst_rmw_write", 32'(mem_write), 32'd1);
    check_output("rst_rmw_ready", 32'(req_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_output("rst_write_drop", 32'(mem_write), 32'd0);
    check_output("rst_read_low", 32'(mem_read), 32'd0);
    check_output("rst_idle", 32'(req_ready), 32'd1);
    check_output("rst_rdata", resp_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rst_no_resp", 32'(resp_valid), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    check_output("rst_mem_word", mem[5], 32'h11223344);
    apply_stimulus(1'b0, F3_W, 32'h14, 32'h0, 32'h11223344, ERR_OK, 1, 1, 0, "lw_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
